// File: rtl/cavlc_pkg.sv
// Shared constants for the CAVLC coefficient statistics block.
package cavlc_pkg;

  localparam int unsigned DEF_WIDTH    = 9;
  localparam int unsigned DEF_NUM_COEF = 16;
  localparam int unsigned DEF_CNT_W    = 5;

  // Two-state block FSM: collecting coefficients, then holding results
  localparam logic ST_ACCUM = 1'b0;
  localparam logic ST_HOLD  = 1'b1;

  // Trailing-ones count saturates here
  localparam logic [1:0] T1_MAX = 2'd3;

endpackage

// File: rtl/cavlc_level_buf.sv
// Simple dual-port level RAM: one write port, one synchronous read port (1-cycle latency).
// Contents are not reset.
module cavlc_level_buf #(
  parameter int unsigned Width = 9,
  parameter int unsigned Depth = 16,
  parameter int unsigned AddrW = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  // Write and registered read share the clock
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/cavlc_coeff_stats.sv
// CAVLC header statistics for one 4x4 block of zigzag-ordered coefficients:
// TotalCoeff, TrailingOnes, T1 signs and TotalZeros, held under valid/ready.
// Optional level buffer enabled by defining CAVLC_LEVEL_BUF_EN.
module cavlc_coeff_stats
  import cavlc_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned NUM_COEF = DEF_NUM_COEF,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             stats_valid,
  input  logic             stats_ready,
  output logic [CNT_W-1:0] total_coeff,
  output logic [1:0]       trailing_ones,
  output logic [2:0]       t1_signs,
  output logic [3:0]       total_zeros
`ifdef CAVLC_LEVEL_BUF_EN
  ,
  input  logic [3:0]       lvl_rd_addr,
  output logic [WIDTH-1:0] lvl_rd_data
`endif
);

  localparam int unsigned IdxW = $clog2(NUM_COEF);

  logic            state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [IdxW-1:0] last_nz_q, last_nz_d;
  logic [CNT_W-1:0] tc_q, tc_d;
  logic [1:0]      t1_q, t1_d;
  logic [2:0]      sr_q, sr_d;

  logic accept;
  logic is_nz;
  logic is_one;

  assign accept = in_valid && (state_q == ST_ACCUM);
  assign is_nz  = (in_data != '0);
  // Direct compare against +1 / -1 so -2^(WIDTH-1) never goes through an abs()
  assign is_one = (in_data == WIDTH'(1)) || (in_data == {WIDTH{1'b1}});

  // Next-state: accumulate on accepted beats, clear on stats handshake
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_nz_d = last_nz_q;
    tc_d      = tc_q;
    t1_d      = t1_q;
    sr_d      = sr_q;
    if (accept) begin
      if (is_nz) begin
        tc_d      = tc_q + CNT_W'(1);
        last_nz_d = idx_q;
        if (is_one) begin
          t1_d = (t1_q == T1_MAX) ? T1_MAX : t1_q + 2'd1;
          sr_d = {sr_q[1:0], in_data[WIDTH-1]};
        end else begin
          t1_d = '0;
          sr_d = '0;
        end
      end
      if (idx_q == IdxW'(NUM_COEF - 1)) begin
        idx_d   = '0;
        state_d = ST_HOLD;
      end else begin
        idx_d = idx_q + IdxW'(1);
      end
    end else if ((state_q == ST_HOLD) && stats_ready) begin
      state_d   = ST_ACCUM;
      idx_d     = '0;
      last_nz_d = '0;
      tc_d      = '0;
      t1_d      = '0;
      sr_d      = '0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ACCUM;
      idx_q     <= '0;
      last_nz_q <= '0;
      tc_q      <= '0;
      t1_q      <= '0;
      sr_q      <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_nz_q <= last_nz_d;
      tc_q      <= tc_d;
      t1_q      <= t1_d;
      sr_q      <= sr_d;
    end
  end

  // Outputs come straight from registers; total_zeros uses mod-16 arithmetic,
  // which equals the low 4 bits of the full-width difference
  always_comb begin
    in_ready      = (state_q == ST_ACCUM);
    stats_valid   = (state_q == ST_HOLD);
    total_coeff   = tc_q;
    trailing_ones = t1_q;
    t1_signs      = sr_q;
    total_zeros   = (tc_q == '0) ? 4'd0 : (4'(last_nz_q) + 4'd1 - tc_q[3:0]);
  end

`ifdef CAVLC_LEVEL_BUF_EN
  // Nonzero levels stored in arrival order at address tc
  cavlc_level_buf #(
    .Width (WIDTH),
    .Depth (NUM_COEF),
    .AddrW (4)
  ) u_level_buf (
    .clk_i   (clk),
    .we_i    (accept && is_nz),
    .waddr_i (tc_q[3:0]),
    .wdata_i (in_data),
    .raddr_i (lvl_rd_addr),
    .rdata_o (lvl_rd_data)
  );
`endif

endmodule
